// File: rtl/regfile_pkg.sv
// Shared defaults for the multi-port register file and its scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 3;
  localparam int NUM_WR_DEF = 2;

  // Register index that always reads as zero and never holds state.
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by accepted reservations,
// cleared by committed writes, plus a registered population count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_WR = NUM_WR_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic                     rsv_en_i,
  input  logic [ADDR_W-1:0]        rsv_addr_i,
  output logic                     rsv_ok_o,
  output logic [(2**ADDR_W)-1:0]   pending_o,
  output logic [ADDR_W:0]          pend_cnt_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;

  assign rsv_ok_o = rsv_en_i && ((rsv_addr_i == ZERO_ADDR) || !pend_q[rsv_addr_i]);

  // Clears are applied before the set so an accepted reserve wins over a
  // same-cycle write to the same register.
  always_comb begin
    pend_d = pend_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] != ZERO_ADDR)) begin
        pend_d[wr_addr_i[w*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (rsv_ok_o && (rsv_addr_i != ZERO_ADDR)) begin
      pend_d[rsv_addr_i] = 1'b1;
    end
    pend_d[ZERO_REG] = 1'b0;

    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + (ADDR_W+1)'(pend_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending_o  = pend_q;
  assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with combinational reads, highest-port-wins writes
// and a destination-reservation scoreboard. Optional forwarding: REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int NUM_WR = NUM_WR_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ok,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pending;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr),
    .rsv_ok_o   (rsv_ok),
    .pending_o  (pending),
    .pend_cnt_o (pend_cnt)
  );

  // Ascending port order lets the highest-index port overwrite earlier ones.
  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] != ZERO_ADDR)) begin
        mem_d[wr_addr[w*ADDR_W +: ADDR_W]] = wr_data[w*DATA_W +: DATA_W];
      end
    end
    mem_d[ZERO_REG] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_addr[k*ADDR_W +: ADDR_W] != ZERO_ADDR) begin
        rd_data[k*DATA_W +: DATA_W] = mem_q[rd_addr[k*ADDR_W +: ADDR_W]];
        rd_busy[k]                  = pending[rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
        // A write landing this edge makes the register no longer busy for this reader.
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[k*ADDR_W +: ADDR_W])) begin
            rd_data[k*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
            rd_busy[k]                  = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers, index 0 hardwired zero.
REQ-003 SHALL have parameter NUM_RD, default 3, read port count.
REQ-004 SHALL have parameter NUM_WR, default 2, write port count.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port rd_addr, input, NUM_RD*ADDR_W, packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rd_data, output, NUM_RD*DATA_W, packed read data, same packing rule.
REQ-009 SHALL have port rd_busy, output, NUM_RD, per-read-port pending-write flag.
REQ-010 SHALL have port wr_en, input, NUM_WR, per-write-port enable.
REQ-011 SHALL have port wr_addr, input, NUM_WR*ADDR_W, packed write addresses.
REQ-012 SHALL have port wr_data, input, NUM_WR*DATA_W, packed write data.
REQ-013 SHALL have port rsv_en, input, 1, request to reserve a destination register.
REQ-014 SHALL have port rsv_addr, input, ADDR_W, register to reserve.
REQ-015 SHALL have port rsv_ok, output, 1, reservation accepted this cycle.
REQ-016 SHALL have port pend_cnt, output, ADDR_W+1, registered count of pending registers.

Function
REQ-017 Reads SHALL be combinational, zero latency; rd_addr 0 returns 0 and rd_busy 0.
REQ-018 Writes SHALL commit at the rising edge when wr_en set and wr_addr nonzero; writes to 0 ignored.
REQ-019 Several ports writing one address in one cycle: highest-index port SHALL win.
REQ-020 Scoreboard SHALL hold one pending bit per register 1..DEPTH-1; rd_busy[k] = pending[rd_addr k].
REQ-021 rsv_ok SHALL be rsv_en AND (rsv_addr==0 OR pending[rsv_addr]==0), combinational; accepted nonzero address sets its bit next edge.
REQ-022 Any committed write SHALL clear the pending bit of its address next edge.
REQ-023 Same-cycle write and accepted reserve to one address: reserve wins, bit ends set, data still commits.
REQ-024 Same-cycle write and refused reserve (already pending): bit ends clear.
REQ-025 pend_cnt SHALL equal the population count of pending bits after every edge; never exceeds DEPTH-1.

Reset
REQ-026 rst high at an edge SHALL zero all registers, all pending bits and pend_cnt, overriding same-cycle writes and reserves.
REQ-027 After reset all rd_data and rd_busy SHALL read 0; rsv_ok follows REQ-021 combinationally, also during reset.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN defined: rd_data SHALL forward wr_data of highest-index enabled write port matching a nonzero rd_addr in the same cycle, and rd_busy SHALL read 0 for that port.
REQ-029 Macro absent: reads SHALL return stored value only; written data visible the cycle after the edge.

Structure
REQ-030 Package regfile_pkg SHALL hold default DATA_W/ADDR_W/NUM_RD/NUM_WR constants and the zero-register index constant.
REQ-031 Pending bits, reserve/clear logic and pend_cnt SHALL live in sub-module regfile_scoreboard; regfile_mp instantiates it once.

Verification
REQ-032 rst=1 one cycle, then read addr 1..31 -> all rd_data 0, rd_busy 0, pend_cnt 0.
REQ-033 wr port0 addr 5 data 0xDEADBEEF, port1 addr 5 data 0x12345678 same cycle -> next cycle addr 5 reads 0x12345678; write addr 0 data 0xFFFFFFFF -> addr 0 reads 0.
REQ-034 Reserve 7 -> rsv_ok 1, pend_cnt 1, rd_busy 1 for addr 7; reserve 7 again -> rsv_ok 0; write 7 -> busy 0, pend_cnt 0.
REQ-035 Write addr 9 data 0xA5A5A5A5 while reading 9 -> same cycle 0xA5A5A5A5 with REGFILE_BYPASS_EN, old value without.
REQ-036 Write 3 and reserve 3 (not pending) same cycle -> pending set, pend_cnt 1; rst asserted with active write to 4 -> addr 4 reads 0.
